// File: rtl/imager_readout_fsm.sv
// Row-readout sequencer: FSMIND handshake responder stepping rows through settle/sample/convert.
// Optional ROREAD_INSYNC_EN adds 2-flop synchronizers on FSMIND1 and FSMIND0ACK.
module imager_readout_fsm #(
  parameter int C_NUM_ROWS   = 160,
  parameter int C_ROW_ADDR_W = 8,
  parameter int C_ROW_SETTLE = 8,
  parameter int C_ADC_CONV   = 36
) (
  input  logic                    CLK_HS,
  input  logic                    RESET,
  input  logic                    FSMIND1,
  output logic                    FSMIND1ACK,
  output logic                    FSMIND0,
  input  logic                    FSMIND0ACK,
  output logic                    ROW_SEL,
  output logic [C_ROW_ADDR_W-1:0] ROW_ADDR,
  output logic                    ADC_SAMPLE,
  output logic                    ADC_CONV,
  output logic                    ROW_DONE,
  output logic [8:1]              fsm_stat,
  output logic [31:0]             CntFrame
);

  localparam int CNT_MAX = (C_ROW_SETTLE > C_ADC_CONV) ? C_ROW_SETTLE : C_ADC_CONV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]        SET_LAST  = CNT_W'(C_ROW_SETTLE - 1);
  localparam logic [CNT_W-1:0]        CONV_LAST = CNT_W'(C_ADC_CONV - 1);
  localparam logic [C_ROW_ADDR_W-1:0] ROW_LAST  = C_ROW_ADDR_W'(C_NUM_ROWS - 1);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_ACK    = 6'b000010,
    S_SETTLE = 6'b000100,
    S_SAMPLE = 6'b001000,
    S_CONV   = 6'b010000,
    S_FSM0   = 6'b100000
  } state_t;

  state_t                    state, nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [C_ROW_ADDR_W-1:0]   row_nxt;
  logic                      frame_inc;
  logic                      ind1, ind0ack;
  logic [8:1]                stat_nxt;

`ifdef ROREAD_INSYNC_EN
  logic [1:0] sync1, sync0;
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      sync1 <= '0;
      sync0 <= '0;
    end else begin
      sync1 <= {sync1[0], FSMIND1};
      sync0 <= {sync0[0], FSMIND0ACK};
    end
  end
  assign ind1    = sync1[1];
  assign ind0ack = sync0[1];
`else
  assign ind1    = FSMIND1;
  assign ind0ack = FSMIND0ACK;
`endif

  // Next state, counter and row address; a stale ACK from the last frame blocks a restart.
  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt;
    row_nxt   = ROW_ADDR;
    frame_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (ind1 && !ind0ack) begin
          nxt     = S_ACK;
          cnt_nxt = '0;
          row_nxt = '0;
        end
      end
      S_ACK: begin
        nxt     = S_SETTLE;
        cnt_nxt = '0;
        row_nxt = '0;
      end
      S_SETTLE: begin
        if (cnt == SET_LAST) begin
          nxt     = S_SAMPLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        nxt     = S_CONV;
        cnt_nxt = '0;
      end
      S_CONV: begin
        if (cnt == CONV_LAST) begin
          cnt_nxt = '0;
          if (ROW_ADDR == ROW_LAST) begin
            nxt = S_FSM0;
          end else begin
            nxt     = S_SETTLE;
            row_nxt = ROW_ADDR + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_FSM0: begin
        if (ind0ack) begin
          nxt       = S_IDLE;
          frame_inc = 1'b1;
        end
      end
      default: begin
        nxt     = S_IDLE;
        cnt_nxt = '0;
        row_nxt = '0;
      end
    endcase
  end

  always_comb begin
    stat_nxt = 8'hF1;
    case (nxt)
      S_ACK:    stat_nxt = 8'hF2;
      S_SETTLE: stat_nxt = 8'hF3;
      S_SAMPLE: stat_nxt = 8'hF4;
      S_CONV:   stat_nxt = 8'hF5;
      S_FSM0:   stat_nxt = 8'hF6;
      default:  stat_nxt = 8'hF1;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state they describe.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ROW_ADDR   <= '0;
      FSMIND1ACK <= 1'b0;
      FSMIND0    <= 1'b0;
      ROW_SEL    <= 1'b0;
      ADC_SAMPLE <= 1'b0;
      ADC_CONV   <= 1'b0;
      ROW_DONE   <= 1'b0;
      fsm_stat   <= 8'b10100101;
      CntFrame   <= '0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      ROW_ADDR   <= row_nxt;
      FSMIND1ACK <= (nxt == S_ACK) || (nxt == S_SETTLE) || (nxt == S_SAMPLE) ||
                    (nxt == S_CONV) || (nxt == S_FSM0);
      FSMIND0    <= (nxt == S_FSM0);
      ROW_SEL    <= (nxt == S_SETTLE) || (nxt == S_SAMPLE);
      ADC_SAMPLE <= (nxt == S_SAMPLE);
      ADC_CONV   <= (nxt == S_CONV);
      ROW_DONE   <= (nxt == S_CONV) && (cnt_nxt == CONV_LAST);
      fsm_stat   <= stat_nxt;
      if (frame_inc) CntFrame <= CntFrame + 32'd1;
    end
  end

endmodule

// File: tb/tb_imager_readout_fsm.sv
// Directed bench for imager_readout_fsm with 4 rows, settle 2, conv 3 (row period 6).
module tb_imager_readout_fsm;

`ifdef ROREAD_INSYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic        CLK_HS = 1'b0;
  logic        RESET;
  logic        FSMIND1, FSMIND0ACK;
  logic        FSMIND1ACK, FSMIND0, ROW_SEL, ADC_SAMPLE, ADC_CONV, ROW_DONE;
  logic [2:0]  ROW_ADDR;
  logic [8:1]  fsm_stat;
  logic [31:0] CntFrame;

  int errors = 0;
  int checks = 0;

  imager_readout_fsm #(
    .C_NUM_ROWS(4), .C_ROW_ADDR_W(3), .C_ROW_SETTLE(2), .C_ADC_CONV(3)
  ) dut (
    .CLK_HS(CLK_HS), .RESET(RESET), .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK), .ROW_SEL(ROW_SEL), .ROW_ADDR(ROW_ADDR),
    .ADC_SAMPLE(ADC_SAMPLE), .ADC_CONV(ADC_CONV), .ROW_DONE(ROW_DONE),
    .fsm_stat(fsm_stat), .CntFrame(CntFrame)
  );

  always #5 CLK_HS = ~CLK_HS;

  task automatic tick();
    @(posedge CLK_HS);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs at cycle d after FSMIND1 is seen (d=1 is the ACK cycle, rows start at d=2).
  task automatic chk_frame(input int d);
    int p, ph, row;
    logic inrow;
    logic [7:0] st;
    p     = d - 2;
    inrow = (d >= 2) && (d < 26);
    ph    = inrow ? p % 6 : 0;
    row   = inrow ? p / 6 : 0;
    if (d < 1)       st = 8'hF1;
    else if (d == 1) st = 8'hF2;
    else if (d >= 26) st = 8'hF6;
    else if (ph < 2) st = 8'hF3;
    else if (ph == 2) st = 8'hF4;
    else             st = 8'hF5;
    chk($sformatf("stat d=%0d", d), fsm_stat, st);
    chk($sformatf("ind1ack d=%0d", d), FSMIND1ACK, d >= 1);
    chk($sformatf("ind0 d=%0d", d), FSMIND0, d >= 26);
    chk($sformatf("rowsel d=%0d", d), ROW_SEL, inrow && ph <= 2);
    chk($sformatf("sample d=%0d", d), ADC_SAMPLE, inrow && ph == 2);
    chk($sformatf("conv d=%0d", d), ADC_CONV, inrow && ph >= 3);
    chk($sformatf("rowdone d=%0d", d), ROW_DONE, inrow && ph == 5);
    if (d >= 1) chk($sformatf("rowaddr d=%0d", d), ROW_ADDR, (d < 2) ? 0 : (d >= 26) ? 3 : row);
  endtask

  task automatic chk_idle_zero(input string tag, input logic [7:0] st);
    chk({tag, " stat"}, fsm_stat, st);
    chk({tag, " outs"}, {FSMIND1ACK, FSMIND0, ROW_SEL, ADC_SAMPLE, ADC_CONV, ROW_DONE}, 0);
    chk({tag, " rowaddr"}, ROW_ADDR, 0);
  endtask

  initial begin
    int samples;
    RESET = 1'b1; FSMIND1 = 1'b0; FSMIND0ACK = 1'b0;
    tick(); tick();
    chk_idle_zero("reset", 8'hA5);
    chk("reset cnt", CntFrame, 0);
    RESET = 1'b0;
    tick();
    chk_idle_zero("idle", 8'hF1);

    // Scenario 1: full frame timing
    FSMIND1 = 1'b1;
    for (int k = 1; k <= 26 + SD; k++) begin
      tick();
      chk_frame(k - SD);
    end

    // Scenario 2: FSMIND0 held until ACK
    FSMIND1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("ind0 hold", FSMIND0, 1);
      chk("cnt hold", CntFrame, 0);
    end
    FSMIND0ACK = 1'b1;
    for (int k = 0; k < SD; k++) begin
      tick();
      chk("ind0 sync hold", FSMIND0, 1);
    end
    tick();
    chk("ack ind0", FSMIND0, 0);
    chk("ack ind1ack", FSMIND1ACK, 0);
    chk("ack cnt", CntFrame, 1);
    chk("ack stat", fsm_stat, 8'hF1);

    // Scenario 3: stale ACK blocks restart
    FSMIND1 = 1'b1;
    for (int k = 0; k < 5 + SD; k++) begin
      tick();
      chk("stale stat", fsm_stat, 8'hF1);
      chk("stale ind1ack", FSMIND1ACK, 0);
    end
    FSMIND0ACK = 1'b0;
    for (int k = 1; k <= 17 + SD; k++) begin
      tick();
      chk_frame(k - SD);
    end

    // Scenario 4: reset during row 2 conversion
    chk("row2 conv", {ADC_CONV, ROW_ADDR}, {1'b1, 3'd2});
    RESET = 1'b1;
    tick();
    chk_idle_zero("midreset", 8'hA5);
    chk("midreset cnt", CntFrame, 0);
    RESET = 1'b0;

    // Scenario 5: FSMIND1 dropped mid-readout does not abort
    samples = 0;
    for (int k = 1; k <= 26 + SD; k++) begin
      tick();
      chk_frame(k - SD);
      if (ADC_SAMPLE) samples++;
      if (k - SD == 8)  FSMIND1 = 1'b0;
      if (k - SD == 11) FSMIND1 = 1'b1;
    end
    chk("sample count", samples, 4);
    FSMIND0ACK = 1'b1;
    for (int k = 0; k <= SD; k++) tick();
    chk("frame2 ind0", FSMIND0, 0);
    chk("frame2 cnt", CntFrame, 1);
    tick(); tick();
    chk("no restart stat", fsm_stat, 8'hF1);
    FSMIND1 = 1'b0; FSMIND0ACK = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
